// File: rtl/jtdsp16_pbus_pkg.sv
// jtdsp16_pbus_pkg
// Shared definitions for the DSP16 parallel-port host bridge:
//   - bit positions of the status word returned on a psel=1 read
//   - bit positions of the control word accepted on a psel=1 write
//   - helper that assembles the status word
package jtdsp16_pbus_pkg;

  localparam int ST_DVALID = 15;
  localparam int ST_DOVF   = 14;
  localparam int ST_DUNF   = 13;
  localparam int ST_HOVF   = 12;

  localparam int CT_FLUSH  = 0;
  localparam int CT_CLR    = 1;

  // i_cnt is the FIFO count zero-extended to 12 bits; it lands in the low bits.
  function automatic logic [15:0] status_word(input logic       i_dvalid,
                                              input logic       i_dovf,
                                              input logic       i_dunf,
                                              input logic       i_hovf,
                                              input logic [11:0] i_cnt);
    logic [15:0] w_s;
    w_s            = {4'd0, i_cnt};
    w_s[ST_DVALID] = i_dvalid;
    w_s[ST_DOVF]   = i_dovf;
    w_s[ST_DUNF]   = i_dunf;
    w_s[ST_HOVF]   = i_hovf;
    return w_s;
  endfunction

endpackage

// File: rtl/jtdsp16_pbus_fifo.sv
// jtdsp16_pbus_fifo
// Synchronous FIFO of 16-bit words, depth 2**FIFO_AW.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push, i_din write request and data (accepted when not full, or when
//                 a pop happens in the same cycle)
//   i_pop         read request (ignored when empty)
//   i_flush       empties the FIFO; overrides a simultaneous push/pop
//   o_head        word at the read pointer (undefined when empty)
//   o_count       number of stored words, FIFO_AW+1 bits
//   o_full, o_empty
module jtdsp16_pbus_fifo
  import jtdsp16_pbus_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [15:0]        i_din,
  output logic [15:0]        o_head,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int               DEPTH    = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/jtdsp16_pbus_host.sv
// jtdsp16_pbus_host
// Host-side bridge on the far end of the DSP16 parallel I/O port.
// Host words are queued in a FIFO and returned on DSP data reads; DSP data
// writes land in a host-readable register. irq is high while the FIFO holds data.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ph1               DSP clock enable for strobe edge detection
//   pods_n, pids_n    DSP write / read strobes (active low)
//   psel              0 = data, 1 = status (read) / control (write)
//   pbus_out          DSP write data;  pbus_in: data/status back to the DSP
//   irq               registered "FIFO not empty"
//   host_we/host_din  host push;  host_full: FIFO full
//   host_rd           acknowledges host_dout; host_dout(_valid): DSP-written word
//   host_ovf          sticky: host push dropped because FIFO was full
module jtdsp16_pbus_host
  import jtdsp16_pbus_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1,
  input  logic        pods_n,
  input  logic        pids_n,
  input  logic        psel,
  input  logic [15:0] pbus_out,
  output logic [15:0] pbus_in,
  output logic        irq,
  input  logic        host_we,
  input  logic [15:0] host_din,
  output logic        host_full,
  input  logic        host_rd,
  output logic [15:0] host_dout,
  output logic        host_dout_valid,
  output logic        host_ovf
);

  logic               r_last_pods_n;
  logic               r_last_pids_n;
  logic               r_arm_wr;
  logic               r_arm_rd;
  logic [15:0]        r_dout;
  logic               r_dvalid;
  logic               r_dovf;
  logic               r_dunf;
  logic               r_hovf;
  logic               r_irq;

  logic               w_wr_edge;
  logic               w_rd_end;
  logic               w_data_wr;
  logic               w_ctl_wr;
  logic               w_flush;
  logic               w_clr;
  logic               w_pop;
  logic [15:0]        w_head;
  logic [FIFO_AW:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic [11:0]        w_cnt12;

  // The arm flags stay low after reset until the strobe has been seen high,
  // so a strobe left low across reset cannot fake an edge.
  assign w_wr_edge = ph1 & r_arm_wr & ~pods_n & r_last_pods_n;
  assign w_rd_end  = ph1 & r_arm_rd & pids_n & ~r_last_pids_n;
  assign w_data_wr = w_wr_edge & ~psel;
  assign w_ctl_wr  = w_wr_edge & psel;
  assign w_flush   = w_ctl_wr & pbus_out[CT_FLUSH];
  assign w_clr     = w_ctl_wr & pbus_out[CT_CLR];
  assign w_pop     = w_rd_end & ~psel;

  jtdsp16_pbus_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (host_we),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (host_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_pods_n <= 1'b1;
      r_last_pids_n <= 1'b1;
      r_arm_wr      <= 1'b0;
      r_arm_rd      <= 1'b0;
      r_dout        <= '0;
      r_dvalid      <= 1'b0;
      r_dovf        <= 1'b0;
      r_dunf        <= 1'b0;
      r_hovf        <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (ph1) begin
        r_last_pods_n <= pods_n;
        r_last_pids_n <= pids_n;
      end
      if (pods_n) r_arm_wr <= 1'b1;
      if (pids_n) r_arm_rd <= 1'b1;

      r_irq <= (w_count != '0);

      // Clear first so that a same-cycle set from another source survives.
      if (w_clr) begin
        r_dovf <= 1'b0;
        r_dunf <= 1'b0;
        r_hovf <= 1'b0;
      end

      // A fresh DSP word beats a simultaneous host acknowledge.
      if (w_data_wr) begin
        r_dout   <= pbus_out;
        r_dvalid <= 1'b1;
        if (r_dvalid && !host_rd) r_dovf <= 1'b1;
      end else if (host_rd) begin
        r_dvalid <= 1'b0;
      end

      if (w_pop && w_empty) r_dunf <= 1'b1;

      // A push into a full FIFO is lost unless a pop makes room; a flush
      // discards the push on purpose, which is not an overflow.
      if (host_we && w_full && !(w_pop && !w_empty) && !w_flush) r_hovf <= 1'b1;
    end
  end

  assign w_cnt12 = {{(11-FIFO_AW){1'b0}}, w_count};

  always_comb begin
    pbus_in = '0;
    if (psel)          pbus_in = status_word(r_dvalid, r_dovf, r_dunf, r_hovf, w_cnt12);
    else if (!w_empty) pbus_in = w_head;
  end

  assign irq             = r_irq;
  assign host_full       = w_full;
  assign host_dout       = r_dout;
  assign host_dout_valid = r_dvalid;
  assign host_ovf        = r_hovf;

endmodule

// File: tb/tb_jtdsp16_pbus_host.sv
module tb_jtdsp16_pbus_host;

  logic        clk = 1'b0;
  logic        rst, ph1, pods_n, pids_n, psel, host_we, host_rd;
  logic [15:0] pbus_out, host_din;
  logic [15:0] pbus_in, host_dout;
  logic        irq, host_full, host_dout_valid, host_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  bit          m_dv, m_dovf, m_dunf, m_hovf;

  jtdsp16_pbus_host #(.FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .ph1(ph1), .pods_n(pods_n), .pids_n(pids_n),
    .psel(psel), .pbus_out(pbus_out), .pbus_in(pbus_in), .irq(irq),
    .host_we(host_we), .host_din(host_din), .host_full(host_full),
    .host_rd(host_rd), .host_dout(host_dout), .host_dout_valid(host_dout_valid),
    .host_ovf(host_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s = 16'(mq.size());
    if (m_dv)   s = s + 16'h8000;
    if (m_dovf) s = s + 16'h4000;
    if (m_dunf) s = s + 16'h2000;
    if (m_hovf) s = s + 16'h1000;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic get_status(output logic [15:0] s);
    psel = 1'b1; #1; s = pbus_in; psel = 1'b0; #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ph1 = 1'b0; pods_n = 1'b1; pids_n = 1'b1; psel = 1'b0;
    host_we = 1'b0; host_rd = 1'b0; pbus_out = '0; host_din = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    mq.delete(); m_dout = '0; m_dv = 0; m_dovf = 0; m_dunf = 0; m_hovf = 0;
  endtask

  task automatic host_push(input logic [15:0] d);
    host_we = 1'b1; host_din = d;
    tick();
    host_we = 1'b0;
    tick();
    if (mq.size() < 4) mq.push_back(d); else m_hovf = 1;
  endtask

  task automatic host_read();
    host_rd = 1'b1; tick(); host_rd = 1'b0; tick();
    m_dv = 0;
  endtask

  task automatic dsp_read(input logic ps, output logic [15:0] smp, output logic [15:0] expv);
    expv = ps ? exp_status() : ((mq.size() != 0) ? mq[0] : 16'h0000);
    psel = ps; pids_n = 1'b0;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    smp = pbus_in;
    pids_n = 1'b1;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    psel = 1'b0;
    if (!ps) begin
      if (mq.size() != 0) void'(mq.pop_front()); else m_dunf = 1;
    end
  endtask

  task automatic dsp_write(input logic ps, input logic [15:0] d);
    psel = ps; pbus_out = d; pods_n = 1'b0;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    pods_n = 1'b1;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    psel = 1'b0;
    if (!ps) begin
      if (m_dv) m_dovf = 1;
      m_dout = d; m_dv = 1;
    end else begin
      if (d[0]) mq.delete();
      if (d[1]) begin m_dovf = 0; m_dunf = 0; m_hovf = 0; end
    end
  endtask

  task automatic test_reset();
    logic [15:0] s;
    do_reset();
    checks++; if (pbus_in !== 16'h0000) begin errors++; $display("FAIL reset_pbus_in got %h exp 0000", pbus_in); end
    checks++; if ({irq, host_full, host_dout_valid, host_ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {irq, host_full, host_dout_valid, host_ovf}); end
    checks++; if (host_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", host_dout); end
    get_status(s);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", s); end
  endtask

  task automatic test_push_pop();
    logic [15:0] s, smp, e;
    do_reset();
    host_push(16'h1234); host_push(16'h5678);
    get_status(s);
    checks++; if (s !== 16'h0002) begin errors++; $display("FAIL pp_count2 got %h exp 0002", s); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pp_irq_on got %b exp 1", irq); end
    dsp_read(1'b0, smp, e);
    checks++; if (smp !== 16'h1234) begin errors++; $display("FAIL pp_first got %h exp 1234", smp); end
    get_status(s);
    checks++; if (s !== 16'h0001) begin errors++; $display("FAIL pp_count1 got %h exp 0001", s); end
    psel = 1'b0; pids_n = 1'b0;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    checks++; if (pbus_in !== 16'h5678) begin errors++; $display("FAIL pp_second got %h exp 5678", pbus_in); end
    pids_n = 1'b1; ph1 = 1'b1; tick(); ph1 = 1'b0;
    get_status(s);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL pp_count0 got %h exp 0000", s); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pp_irq_lag got %b exp 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pp_irq_off got %b exp 0", irq); end
    mq.delete();
  endtask

  task automatic test_full_ovf();
    logic [15:0] s, smp, e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      host_push(16'hA000 + 16'(i));
      if (i == 2) begin checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", host_full); end end
      if (i == 3) begin checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL full_4th got %b exp 1", host_full); end end
    end
    checks++; if (host_ovf !== 1'b1) begin errors++; $display("FAIL full_hovf got %b exp 1", host_ovf); end
    get_status(s);
    checks++; if (s !== 16'h1004) begin errors++; $display("FAIL full_status got %h exp 1004", s); end
    for (int i = 0; i < 4; i++) begin
      dsp_read(1'b0, smp, e);
      checks++; if (smp !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, smp, 16'hA000 + 16'(i)); end
    end
  endtask

  task automatic test_dsp_write();
    logic [15:0] s;
    do_reset();
    dsp_write(1'b0, 16'hBEEF);
    checks++; if ({host_dout_valid, host_dout} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL wr_beef got %b/%h exp 1/beef", host_dout_valid, host_dout); end
    dsp_write(1'b0, 16'hCAFE);
    get_status(s);
    checks++; if (s !== 16'hC000 || host_dout !== 16'hCAFE) begin
      errors++; $display("FAIL wr_dovf got %h/%h exp c000/cafe", s, host_dout); end
    dsp_write(1'b1, 16'h0002);
    get_status(s);
    checks++; if (s !== 16'h8000) begin errors++; $display("FAIL wr_clr got %h exp 8000", s); end
    // Data write and host acknowledge in the same cycle.
    psel = 1'b0; pbus_out = 16'h1111; pods_n = 1'b0; ph1 = 1'b1; host_rd = 1'b1;
    tick(); host_rd = 1'b0; ph1 = 1'b0; tick();
    pods_n = 1'b1; ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    get_status(s);
    checks++; if (s !== 16'h8000 || host_dout !== 16'h1111) begin
      errors++; $display("FAIL wr_rd_same got %h/%h exp 8000/1111", s, host_dout); end
    host_read();
    checks++; if (host_dout_valid !== 1'b0) begin errors++; $display("FAIL wr_ack got %b exp 0", host_dout_valid); end
  endtask

  task automatic test_underflow();
    logic [15:0] s, smp, e;
    do_reset();
    dsp_read(1'b0, smp, e);
    checks++; if (smp !== 16'h0000) begin errors++; $display("FAIL unf_data got %h exp 0000", smp); end
    get_status(s);
    checks++; if (s !== 16'h2000) begin errors++; $display("FAIL unf_status got %h exp 2000", s); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s, smp, e;
    do_reset();
    for (int i = 0; i < 4; i++) host_push(16'h0B00 + 16'(i));
    psel = 1'b0; pids_n = 1'b0;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    checks++; if (pbus_in !== 16'h0B00) begin errors++; $display("FAIL b2b_head got %h exp 0b00", pbus_in); end
    pids_n = 1'b1; ph1 = 1'b1; host_we = 1'b1; host_din = 16'h0B04;
    tick(); host_we = 1'b0; ph1 = 1'b0; tick();
    get_status(s);
    checks++; if (s !== 16'h0004) begin errors++; $display("FAIL b2b_status got %h exp 0004", s); end
    mq.delete();
    for (int i = 1; i < 5; i++) mq.push_back(16'h0B00 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      dsp_read(1'b0, smp, e);
      checks++; if (smp !== e) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", i, smp, e); end
    end
  endtask

  task automatic test_flush_push();
    logic [15:0] s;
    do_reset();
    for (int i = 0; i < 3; i++) host_push(16'h0F00 + 16'(i));
    psel = 1'b1; pbus_out = 16'h0001; pods_n = 1'b0; ph1 = 1'b1;
    host_we = 1'b1; host_din = 16'h0FFF;
    tick(); host_we = 1'b0; ph1 = 1'b0;
    checks++; if (pbus_in !== 16'h0000) begin errors++; $display("FAIL flush_status got %h exp 0000", pbus_in); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq got %b exp 0", irq); end
    pods_n = 1'b1; ph1 = 1'b1; tick(); ph1 = 1'b0; tick(); psel = 1'b0;
    mq.delete();
    host_push(16'h0E0E);
    get_status(s);
    checks++; if (s !== 16'h0001 || pbus_in !== 16'h0E0E) begin
      errors++; $display("FAIL flush_after got %h/%h exp 0001/0e0e", s, pbus_in); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pods_n = 1'b0; psel = 1'b0; pbus_out = 16'hAAAA;
    rst = 1'b1; tick(); rst = 1'b0;
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    checks++; if (host_dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_low got %b exp 0", host_dout_valid); end
    pods_n = 1'b1; ph1 = 1'b1; tick(); ph1 = 1'b0; tick();
    checks++; if (host_dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rise got %b exp 0", host_dout_valid); end
    dsp_write(1'b0, 16'h5A5A);
    checks++; if ({host_dout_valid, host_dout} !== {1'b1, 16'h5A5A}) begin
      errors++; $display("FAIL rstmid_next got %b/%h exp 1/5a5a", host_dout_valid, host_dout); end
  endtask

  task automatic test_random();
    logic [15:0] smp, e;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: host_push(16'($urandom));
        2: begin
          dsp_read(1'b0, smp, e);
          checks++; if (smp !== e) begin errors++; $display("FAIL rnd_read%0d got %h exp %h", it, smp, e); end
        end
        3: dsp_write(1'b0, 16'($urandom));
        4: host_read();
        default: dsp_write(1'b1, 16'($urandom_range(0, 3)));
      endcase
      dsp_read(1'b1, smp, e);
      checks++; if (smp !== e) begin errors++; $display("FAIL rnd_status%0d got %h exp %h", it, smp, e); end
      checks++; if ({irq, host_full, host_dout_valid, host_ovf, host_dout} !==
                    {mq.size() != 0, mq.size() == 4, m_dv, m_hovf, m_dout}) begin
        errors++;
        $display("FAIL rnd_outs%0d got %b%b%b%b/%h exp %b%b%b%b/%h", it, irq, host_full, host_dout_valid,
                 host_ovf, host_dout, mq.size() != 0, mq.size() == 4, m_dv, m_hovf, m_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full_ovf();
    test_dsp_write();
    test_underflow();
    test_back_to_back();
    test_flush_push();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtdsp16_pbus_host.md
# jtdsp16_pbus_host

Host-side bridge on the far end of the DSP16 parallel I/O port, for systems where a host CPU (e.g. the QSound Z80 board logic) feeds and reads the DSP. It decodes the port's active-mode strobes (`pods_n`, `pids_n`, `psel`). Host-written words are buffered in a small FIFO and served on DSP reads. Words written by the DSP are captured into a host-readable register, and an interrupt is raised towards the port's `irq` input while data is pending.

## Interface
Parameters:
- `FIFO_AW`, 2: FIFO address width; depth = 2**FIFO_AW words.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `ph1`  in  1  DSP clock enable; port-side logic advances only when high
- `pods_n`  in  1  output data strobe from port, low = DSP write
- `pids_n`  in  1  input data strobe from port, low = DSP read
- `psel`  in  1  peripheral select from port: 0 = data, 1 = status/control
- `pbus_out`  in  16  data driven by the DSP
- `pbus_in`  out  16  data returned to the DSP
- `irq`  out  1  interrupt request to the port
- `host_we`  in  1  one-`clk` pulse; pushes `host_din`
- `host_din`  in  16  host write data
- `host_full`  out  1  FIFO full
- `host_rd`  in  1  one-`clk` pulse; acknowledges `host_dout`
- `host_dout`  out  16  last word written by the DSP
- `host_dout_valid`  out  1  `host_dout` holds unread data
- `host_ovf`  out  1  sticky: host write dropped because FIFO full

## Operation
- Reset: FIFO empty, `count` = 0.
  - `pbus_in` = 0, `irq` = 0, `host_full` = 0.
  - `host_dout` = 0, `host_dout_valid` = 0, `host_ovf` = 0.
  - Internal `dsp_ovf` = 0, `dsp_unf` = 0.
  - Strobe history registers `last_pods_n` = `last_pids_n` = 1.
- Strobe edges are evaluated on `ph1` cycles only, and `last_*` is updated on the same `ph1` cycles.
  - `wr_edge` = `!pods_n & last_pods_n`.
  - `rd_end` = `pids_n & !last_pids_n`.
- `pbus_in` is combinational from registered state:
  - `psel`=0: FIFO head, or 0 when empty.
  - `psel`=1: status word. Bit 15 = `host_dout_valid`, 14 = `dsp_ovf`, 13 = `dsp_unf`, 12 = `host_ovf`, [FIFO_AW:0] = `count`, remaining bits 0.
- DSP read pops on `rd_end` with `psel`=0:
  - FIFO non-empty: pop the head.
  - FIFO empty: no pop; set `dsp_unf`.
  - `psel`=1: no side effects.
- DSP write on `wr_edge`:
  - `psel`=0: `host_dout` <= `pbus_out`, `host_dout_valid` <= 1. Set `dsp_ovf` if `host_dout_valid` was already 1 and no `host_rd` arrives in the same cycle.
  - `psel`=1, control word: bit 0 flushes the FIFO; bit 1 clears `dsp_ovf`, `dsp_unf` and `host_ovf`. Both may be set together.
- Host write: `host_we` acts on any `clk` cycle, independent of `ph1`.
  - Not full: push.
  - Full: word dropped; set `host_ovf`.
- `host_rd` clears `host_dout_valid` on any `clk` cycle.
- `irq` = registered `count != 0`.

## Timing
- Push→`count`/`pbus_in` visible: 1 `clk`. Pop→next head on `pbus_in`: 1 `clk`.
- `irq` follows `count` with 1 extra `clk`.
- The port samples `pbus_in` on the last low `ph1` cycle of `pids_n`. The pop happens on the following `ph1`, so the sampled word is always the pre-pop head.
- Push and pop in the same `clk`: `count` unchanged, head advances, new word stored.
- Push to a full FIFO that pops in the same cycle: accepted, no `host_ovf`.
- Flush in the same cycle as a push: flush wins, pushed word discarded, `count` = 0.
- `wr_edge` (psel=0) and `host_rd` in the same cycle: new data wins, `host_dout_valid` stays 1, no `dsp_ovf`.
- Pointers wrap modulo depth; `count` is FIFO_AW+1 bits and saturates at depth (full).
- Reset mid-transfer: all state returns to reset values immediately. A strobe still low after reset release produces no edge until it first goes high.

## Structure
- Shared package `jtdsp16_pbus_pkg`:
  - status bit indices (`ST_DVALID`=15, `ST_DOVF`=14, `ST_DUNF`=13, `ST_HOVF`=12);
  - control bit indices (`CT_FLUSH`=0, `CT_CLR`=1).
- Sub-module `jtdsp16_pbus_fifo`: synchronous FIFO with push, pop, flush, head, count, full and empty outputs, parameterised by `FIFO_AW`. Top level holds edge detection, flags, the output register and the `pbus_in` mux.

## Test plan
- Host pushes 16'h1234, 16'h5678; DSP performs two `psel`=0 reads at `stlen`=0. Expected: sampled 16'h1234 then 16'h5678; `count` 2→1→0; `irq` drops 2 `clk` after the final pop.
- Host pushes 5 words with `FIFO_AW`=2. Expected: `host_full` after the 4th, 5th dropped, `host_ovf`=1. Status read (`psel`=1) returns 16'h1004.
- DSP writes 16'hBEEF with `psel`=0. Expected: `host_dout`=16'hBEEF, `host_dout_valid`=1. A second write 16'hCAFE with no `host_rd` sets `dsp_ovf`. Writing control 16'h0002 clears it.
- DSP read on an empty FIFO. Expected: `pbus_in`=0, `dsp_unf`=1, `count` stays 0.
- FIFO full while the DSP pops and the host pushes in the same cycle. Expected: `count` stays 4, no `host_ovf`, FIFO order preserved.
- Control write 16'h0001 with 3 words queued and a simultaneous `host_we`. Expected: `count`=0, `irq`=0, pushed word discarded.
